// File: rtl/rv_keypad_device_pkg.sv
// ---------------------------------------------------------------------------
// rv_keypad_device_pkg
// Shared constants for the keypad peripheral: bus width, the default base
// address of the keypad register window, the register offsets within that
// window and an enum naming them.
// ---------------------------------------------------------------------------
package rv_keypad_device_pkg;

    localparam int XLEN = 32;

    // Byte address of register 0; the window is 16 bytes and 16-byte aligned.
    localparam logic [XLEN-1:0] ADDRESS_KEYPAD = 32'h1000_0100;

    localparam logic [3:0] KEYPAD_STATE   = 4'h0;
    localparam logic [3:0] KEYPAD_PENDING = 4'h4;
    localparam logic [3:0] KEYPAD_MASK    = 4'h8;
    localparam logic [3:0] KEYPAD_EDGE    = 4'hC;

    typedef enum logic [3:0] {
        REG_STATE   = KEYPAD_STATE,
        REG_PENDING = KEYPAD_PENDING,
        REG_MASK    = KEYPAD_MASK,
        REG_EDGE    = KEYPAD_EDGE
    } keypad_reg_e;

endpackage

// File: rtl/rv_keypad_device_if.sv
// ---------------------------------------------------------------------------
// rv_keypad_device_if
// Core data-memory bus as seen by the keypad peripheral.
//   req    request strobe                 (master -> slave)
//   we     1 = write, 0 = read            (master -> slave)
//   be     write byte enables             (master -> slave)
//   addr   byte address                   (master -> slave)
//   wdata  write data                     (master -> slave)
//   rvalid response valid, one cycle late (slave -> master)
//   rdata  read data                      (slave -> master)
// ---------------------------------------------------------------------------
interface rv_keypad_device_if;
    import rv_keypad_device_pkg::*;

    logic              req;
    logic              we;
    logic [XLEN/8-1:0] be;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic              rvalid;
    logic [XLEN-1:0]   rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  rvalid, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output rvalid, rdata
    );

endinterface

// File: rtl/rv_keypad_device_debounce.sv
// ---------------------------------------------------------------------------
// rv_key_debounce
// One active-low key: 2-flop synchroniser, stability counter and debounced
// level, plus single-cycle press/release pulses that coincide with the edge
// on which the debounced level flips.
//   clk_i      clock
//   arstn_i    asynchronous active-low reset
//   key_i      raw key input (0 = pressed)
//   level_o    debounced level (1 = released)
//   press_o    pulse: debounced level is going 1 -> 0 on the next edge
//   release_o  pulse: debounced level is going 0 -> 1 on the next edge
// ---------------------------------------------------------------------------
module rv_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk_i,
    input  logic arstn_i,
    input  logic key_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             level_q;
    logic [CNT_W-1:0] cnt_q;
    logic             synced;
    logic             differ;
    logic             flip;

    assign synced = sync_q[1];
    assign differ = (synced != level_q);
    // The level flips on the edge where the counter has already seen
    // DEBOUNCE_CYCLES-1 differing cycles and the input still differs.
    assign flip   = differ && (cnt_q == CNT_LAST);

    // Synchroniser resets to released so no spurious press after reset.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_i};
        end
    end

    // Any return to the debounced value restarts the count from zero.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else if (flip) begin
            level_q <= synced;
            cnt_q   <= '0;
        end else if (differ) begin
            cnt_q   <= cnt_q + 1'b1;
        end else begin
            cnt_q   <= '0;
        end
    end

    assign level_o   = level_q;
    assign press_o   = flip && level_q;
    assign release_o = flip && !level_q;

endmodule

// File: rtl/rv_keypad_device.sv
// ---------------------------------------------------------------------------
// rv_keypad_device
// Memory-mapped multi-key input peripheral on the core data-memory bus.
// Registers (byte offsets from BASE_ADDR):
//   0x0 STATE     RO   debounced level inverted (1 = pressed)
//   0x4 PENDING   W1C  sticky key events
//   0x8 MASK      RW   interrupt enable per key
//   0xC EDGE_MODE RW   0 = press only, 1 = press and release
// Ports:
//   clk_i    clock
//   arstn_i  asynchronous active-low reset
//   data     rv_keypad_device_if.slave data-memory bus
//   keys_i   raw active-low key inputs
//   irq_o    registered interrupt, |(PENDING & MASK)
// Build option: define RV_KEYPAD_RC_EN to make a PENDING read also clear
// PENDING (legacy read-to-clear); otherwise reads have no side effects.
// ---------------------------------------------------------------------------
module rv_keypad_device
    import rv_keypad_device_pkg::*;
#(
    parameter int              N_KEYS          = 4,
    parameter int              DEBOUNCE_CYCLES = 50000,
    parameter logic [XLEN-1:0] BASE_ADDR       = ADDRESS_KEYPAD
) (
    input  logic                clk_i,
    input  logic                arstn_i,
    rv_keypad_device_if.slave   data,
    input  logic [N_KEYS-1:0]   keys_i,
    output logic                irq_o
);

    logic [N_KEYS-1:0] level;
    logic [N_KEYS-1:0] press_pulse;
    logic [N_KEYS-1:0] rel_pulse;

    logic [N_KEYS-1:0] pending_q, pending_d;
    logic [N_KEYS-1:0] mask_q, mask_d;
    logic [N_KEYS-1:0] edge_mode_q, edge_mode_d;

    logic              accept;
    logic              wr_en;
    logic              rd_en;
    keypad_reg_e       reg_sel;
    logic [XLEN-1:0]   be_mask;
    logic [N_KEYS-1:0] be_keys;
    logic [N_KEYS-1:0] wdata_keys;
    logic [XLEN-1:0]   rd_val;
    logic [XLEN-1:0]   rdata_q;
    logic              rvalid_q;
    logic              irq_q;
    logic              unused_bits;

    genvar k;
    generate
        for (k = 0; k < N_KEYS; k++) begin : g_key
            rv_key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk_i     (clk_i),
                .arstn_i   (arstn_i),
                .key_i     (keys_i[k]),
                .level_o   (level[k]),
                .press_o   (press_pulse[k]),
                .release_o (rel_pulse[k])
            );
        end
    endgenerate

    // Every byte of the 16-byte window maps onto one of the four words.
    assign accept  = data.req && (data.addr[XLEN-1:4] == BASE_ADDR[XLEN-1:4]);
    assign wr_en   = accept && data.we;
    assign rd_en   = accept && !data.we;
    assign reg_sel = keypad_reg_e'({data.addr[3:2], 2'b00});

    // Expand byte enables to a bit mask so writes only touch enabled lanes.
    always_comb begin
        be_mask = '0;
        for (int i = 0; i < XLEN; i++) begin
            be_mask[i] = data.be[i/8];
        end
    end

    assign be_keys     = be_mask[N_KEYS-1:0];
    assign wdata_keys  = data.wdata[N_KEYS-1:0] & be_keys;
    assign unused_bits = ^{be_mask, data.wdata, data.addr};

    // Register next-state. Events are OR-ed in last so that they win over a
    // same-cycle W1C (or read-to-clear) of the same bit.
    always_comb begin
        mask_d      = mask_q;
        edge_mode_d = edge_mode_q;
        pending_d   = pending_q;
        if (wr_en) begin
            case (reg_sel)
                REG_MASK:    mask_d      = (mask_q & ~be_keys) | wdata_keys;
                REG_EDGE:    edge_mode_d = (edge_mode_q & ~be_keys) | wdata_keys;
                REG_PENDING: pending_d   = pending_q & ~wdata_keys;
                default:     ;
            endcase
        end
`ifdef RV_KEYPAD_RC_EN
        if (rd_en && (reg_sel == REG_PENDING)) begin
            pending_d = '0;
        end
`endif
        pending_d = pending_d | press_pulse | (rel_pulse & edge_mode_q);
    end

    // Read mux uses pre-edge register values, so a read that coincides with
    // an event returns the value before the event.
    always_comb begin
        rd_val = '0;
        case (reg_sel)
            REG_STATE:   rd_val[N_KEYS-1:0] = ~level;
            REG_PENDING: rd_val[N_KEYS-1:0] = pending_q;
            REG_MASK:    rd_val[N_KEYS-1:0] = mask_q;
            REG_EDGE:    rd_val[N_KEYS-1:0] = edge_mode_q;
            default:     rd_val = '0;
        endcase
    end

    // Control and status registers.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            pending_q   <= '0;
            mask_q      <= '0;
            edge_mode_q <= '0;
        end else begin
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            edge_mode_q <= edge_mode_d;
        end
    end

    // One-cycle response to every accepted request; writes answer with zero.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            rvalid_q <= accept;
            rdata_q  <= rd_en ? rd_val : '0;
            irq_q    <= |(pending_q & mask_q);
        end
    end

    assign data.rvalid = rvalid_q;
    assign data.rdata  = rdata_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_rv_keypad_device.sv
// ---------------------------------------------------------------------------
// tb_rv_keypad_device
// Directed self-checking bench for rv_keypad_device with N_KEYS=4 and
// DEBOUNCE_CYCLES=4. Inputs change on the falling clock edge; outputs are
// sampled on the falling edge. Honours RV_KEYPAD_RC_EN when defined.
// ---------------------------------------------------------------------------
module tb_rv_keypad_device;
    import rv_keypad_device_pkg::*;

    localparam int              N_KEYS = 4;
    localparam int              DEB    = 4;
    localparam logic [XLEN-1:0] BASE   = ADDRESS_KEYPAD;
    localparam logic [XLEN-1:0] A_STATE   = BASE + 32'h0;
    localparam logic [XLEN-1:0] A_PENDING = BASE + 32'h4;
    localparam logic [XLEN-1:0] A_MASK    = BASE + 32'h8;
    localparam logic [XLEN-1:0] A_EDGE    = BASE + 32'hC;

    logic              clk_i = 1'b0;
    logic              arstn_i;
    logic [N_KEYS-1:0] keys;
    logic              irq;

    int compared   = 0;
    int mismatched = 0;

`ifdef RV_KEYPAD_RC_EN
    localparam logic [XLEN-1:0] EXP_SECOND_READ = 32'h0;
`else
    localparam logic [XLEN-1:0] EXP_SECOND_READ = 32'h1;
`endif

    rv_keypad_device_if bus_if ();

    rv_keypad_device #(
        .N_KEYS          (N_KEYS),
        .DEBOUNCE_CYCLES (DEB),
        .BASE_ADDR       (BASE)
    ) dut (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .data    (bus_if),
        .keys_i  (keys),
        .irq_o   (irq)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [XLEN-1:0] observed,
                               input logic [XLEN-1:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Called just after a falling edge: drives one request, which the DUT
    // accepts on the next rising edge, then checks the response one falling
    // edge later and drops the request.
    task automatic applyStimulus(input string tag, input logic we,
                                 input logic [XLEN-1:0] addr, input logic [XLEN-1:0] wdata,
                                 input logic [3:0] be, input logic exp_rvalid,
                                 input logic [XLEN-1:0] exp_rdata);
        bus_if.req   = 1'b1;
        bus_if.we    = we;
        bus_if.addr  = addr;
        bus_if.wdata = wdata;
        bus_if.be    = be;
        @(negedge clk_i);
        checkOutput({tag, " rvalid"}, {31'b0, bus_if.rvalid}, {31'b0, exp_rvalid});
        checkOutput({tag, " rdata"}, bus_if.rdata, exp_rdata);
        bus_if.req   = 1'b0;
        bus_if.we    = 1'b0;
        bus_if.be    = 4'h0;
        bus_if.wdata = '0;
    endtask

    initial begin
        arstn_i      = 1'b0;
        keys         = '1;
        bus_if.req   = 1'b0;
        bus_if.we    = 1'b0;
        bus_if.be    = 4'h0;
        bus_if.addr  = '0;
        bus_if.wdata = '0;

        // Reset defaults
        repeat (3) @(negedge clk_i);
        checkOutput("reset irq", {31'b0, irq}, 32'h0);
        checkOutput("reset rvalid", {31'b0, bus_if.rvalid}, 32'h0);
        checkOutput("reset rdata", bus_if.rdata, 32'h0);
        arstn_i = 1'b1;
        @(negedge clk_i);
        applyStimulus("rst STATE",   1'b0, A_STATE,   '0, 4'h0, 1'b1, 32'h0);
        applyStimulus("rst PENDING", 1'b0, A_PENDING, '0, 4'h0, 1'b1, 32'h0);
        applyStimulus("rst MASK",    1'b0, A_MASK,    '0, 4'h0, 1'b1, 32'h0);
        applyStimulus("rst EDGE",    1'b0, A_EDGE,    '0, 4'h0, 1'b1, 32'h0);
        @(negedge clk_i);
        checkOutput("rvalid single cycle", {31'b0, bus_if.rvalid}, 32'h0);
        checkOutput("rst irq after reads", {31'b0, irq}, 32'h0);

        // Glitch of 3 cycles is rejected
        keys[0] = 1'b0;
        repeat (3) @(negedge clk_i);
        keys[0] = 1'b1;
        repeat (10) @(negedge clk_i);
        applyStimulus("glitch STATE",   1'b0, A_STATE,   '0, 4'h0, 1'b1, 32'h0);
        applyStimulus("glitch PENDING", 1'b0, A_PENDING, '0, 4'h0, 1'b1, 32'h0);

        // Real press: flips on the 6th edge after the fall
        keys[0] = 1'b0;
        repeat (5) @(negedge clk_i);
        applyStimulus("press STATE edge6", 1'b0, A_STATE,   '0, 4'h0, 1'b1, 32'h0);
        applyStimulus("press STATE edge7", 1'b0, A_STATE,   '0, 4'h0, 1'b1, 32'h1);
        applyStimulus("press PENDING",     1'b0, A_PENDING, '0, 4'h0, 1'b1, 32'h1);
        applyStimulus("w1c key0",          1'b1, A_PENDING, 32'h1, 4'hF, 1'b1, 32'h0);
        applyStimulus("after w1c key0",    1'b0, A_PENDING, '0, 4'h0, 1'b1, 32'h0);

        // Mask and irq timing
        applyStimulus("write MASK", 1'b1, A_MASK, 32'h2, 4'hF, 1'b1, 32'h0);
        applyStimulus("read MASK",  1'b0, A_MASK, '0, 4'h0, 1'b1, 32'h2);
        keys[1] = 1'b0;
        repeat (6) @(negedge clk_i);
        checkOutput("irq same cycle as PENDING", {31'b0, irq}, 32'h0);
        @(negedge clk_i);
        checkOutput("irq one cycle later", {31'b0, irq}, 32'h1);
        applyStimulus("PENDING key1", 1'b0, A_PENDING, '0, 4'h0, 1'b1, 32'h2);
        applyStimulus("w1c key1",     1'b1, A_PENDING, 32'h2, 4'hF, 1'b1, 32'h0);
        checkOutput("irq held through clear edge", {31'b0, irq}, 32'h1);
        @(negedge clk_i);
        checkOutput("irq deasserted", {31'b0, irq}, 32'h0);
        applyStimulus("PENDING cleared", 1'b0, A_PENDING, '0, 4'h0, 1'b1, 32'h0);

        // Releases in press-only mode leave PENDING alone
        keys[1:0] = 2'b11;
        repeat (10) @(negedge clk_i);
        applyStimulus("release ignored", 1'b0, A_PENDING, '0, 4'h0, 1'b1, 32'h0);
        applyStimulus("released STATE",  1'b0, A_STATE,   '0, 4'h0, 1'b1, 32'h0);

        // Edge mode: key3 both edges, key2 press only
        applyStimulus("write EDGE", 1'b1, A_EDGE, 32'h8, 4'hF, 1'b1, 32'h0);
        applyStimulus("read EDGE",  1'b0, A_EDGE, '0, 4'h0, 1'b1, 32'h8);
        keys[3] = 1'b0;
        repeat (10) @(negedge clk_i);
        applyStimulus("key3 press",   1'b0, A_PENDING, '0, 4'h0, 1'b1, 32'h8);
        applyStimulus("w1c key3",     1'b1, A_PENDING, 32'h8, 4'hF, 1'b1, 32'h0);
        keys[3] = 1'b1;
        repeat (10) @(negedge clk_i);
        applyStimulus("key3 release", 1'b0, A_PENDING, '0, 4'h0, 1'b1, 32'h8);
        applyStimulus("w1c key3 b",   1'b1, A_PENDING, 32'h8, 4'hF, 1'b1, 32'h0);
        keys[2] = 1'b0;
        repeat (10) @(negedge clk_i);
        applyStimulus("key2 press",   1'b0, A_PENDING, '0, 4'h0, 1'b1, 32'h4);
        applyStimulus("w1c key2",     1'b1, A_PENDING, 32'h4, 4'hF, 1'b1, 32'h0);
        keys[2] = 1'b1;
        repeat (10) @(negedge clk_i);
        applyStimulus("key2 release", 1'b0, A_PENDING, '0, 4'h0, 1'b1, 32'h0);

        // W1C on the same edge as a key0 press: the event wins
        keys[0] = 1'b0;
        repeat (5) @(negedge clk_i);
        applyStimulus("collision w1c",     1'b1, A_PENDING, 32'h1, 4'hF, 1'b1, 32'h0);
        applyStimulus("collision PENDING", 1'b0, A_PENDING, '0, 4'h0, 1'b1, 32'h1);
        applyStimulus("second PENDING read", 1'b0, A_PENDING, '0, 4'h0, 1'b1, EXP_SECOND_READ);
        applyStimulus("w1c key0 final", 1'b1, A_PENDING, 32'h1, 4'hF, 1'b1, 32'h0);
        applyStimulus("PENDING final",   1'b0, A_PENDING, '0, 4'h0, 1'b1, 32'h0);

        // Byte enables and decode window
        applyStimulus("MASK be=0",      1'b1, A_MASK, 32'hFF, 4'h0, 1'b1, 32'h0);
        applyStimulus("MASK unchanged", 1'b0, A_MASK, '0, 4'h0, 1'b1, 32'h2);
        applyStimulus("MASK be=1",      1'b1, A_MASK, 32'hFF, 4'h1, 1'b1, 32'h0);
        applyStimulus("MASK low keys",  1'b0, A_MASK, '0, 4'h0, 1'b1, 32'hF);
        applyStimulus("MASK be=2",      1'b1, A_MASK, 32'h0000_0000, 4'h2, 1'b1, 32'h0);
        applyStimulus("MASK lane1 only", 1'b0, A_MASK, '0, 4'h0, 1'b1, 32'hF);
        applyStimulus("STATE via +0x3", 1'b0, BASE + 32'h3, '0, 4'h0, 1'b1, 32'h1);
        applyStimulus("out of window +0x10", 1'b0, BASE + 32'h10, '0, 4'h0, 1'b0, 32'h0);
        applyStimulus("out of window -0x4",  1'b0, BASE - 32'h4,  '0, 4'h0, 1'b0, 32'h0);
        checkOutput("irq idle", {31'b0, irq}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rv_keypad_device.md
Name: rv_keypad_device

Overview:
Memory-mapped multi-key input peripheral on the core data-memory bus. It is the parametrised successor of the single-key device.
- N_KEYS active-low keys, each with a 2-flop synchroniser and a counter debouncer.
- Press/release edge detection feeding a sticky pending register.
- Per-key interrupt mask and a level interrupt output to the core.

Parameters:
N_KEYS, 4, number of key inputs, 1..32.
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before the debounced level changes, ≥1.
BASE_ADDR, ADDRESS_KEYPAD (rv_pkg), byte address of register 0; 16-byte aligned.

Ports:
clk_i  in  1  clock
arstn_i  in  1  asynchronous active-low reset
data_rvalid_o  out  1  response valid, one cycle after an accepted request
data_rdata_o  out  XLEN  read data
data_req_i  in  1  request strobe
data_we_i  in  1  1 = write, 0 = read
data_be_i  in  XLEN/8  write byte enables
data_addr_i  in  XLEN  byte address
data_wdata_i  in  XLEN  write data
keys_i  in  N_KEYS  raw key inputs, active-low (0 = pressed)
irq_o  out  1  registered interrupt, |(PENDING & MASK)

Behaviour:
- Reset is arstn_i, asynchronous, active-low; clock is clk_i. Values on reset:
  - synchroniser flops and debounced level all '1 (released)
  - debounce counters 0; PENDING, MASK, EDGE_MODE 0
  - data_rvalid_o 0, data_rdata_o 0, irq_o 0
- Decode window is BASE_ADDR..BASE_ADDR+0xF. A request is accepted when data_req_i=1 and data_addr_i[XLEN-1:4]==BASE_ADDR[XLEN-1:4].
- Register map (word offsets; bits above N_KEYS read 0, writes ignored):
  - 0x0 STATE: RO, debounced level inverted (1 = pressed).
  - 0x4 PENDING: sticky events, write-1-to-clear.
  - 0x8 MASK: RW interrupt enable.
  - 0xC EDGE_MODE: RW per key; 0 = press only, 1 = press and release.
- Bus timing:
  - Accepted request → data_rvalid_o=1 next cycle, for exactly one cycle; no backpressure; back-to-back requests are each answered.
  - Read: data_rdata_o = register value sampled at the request edge.
  - Write: data_rdata_o = 0. Byte lanes honour data_be_i.
  - Unmapped or out-of-window addresses: no response; data_rvalid_o=0, data_rdata_o=0.
- Debounce, per key:
  - Input passes through a 2-flop synchroniser.
  - If the synced value ≠ debounced value, the counter increments; otherwise it clears to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced value flips and the counter clears.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1). Any glitch shorter than DEBOUNCE_CYCLES restarts the count.
  - Latency from key change to STATE change is 2 + DEBOUNCE_CYCLES cycles.
- Events:
  - Press = debounced 1→0, always sets PENDING[k].
  - Release = debounced 0→1, sets PENDING[k] only if EDGE_MODE[k]=1.
  - An event and a W1C clear of the same bit in the same cycle: the event wins and the bit stays 1.
  - A read in the same cycle as an event returns the pre-event value; the bit is visible on the next read.
- irq_o is registered: asserts one cycle after PENDING&MASK becomes non-zero, and deasserts one cycle after it clears.
- Reset mid-debounce discards the partial count. Keys held during reset produce a press event once debounced after reset.

Optional Feature:
RV_KEYPAD_RC_EN
- Defined: a read of PENDING also clears it (legacy read-to-clear). The returned value is the pre-clear value. An event in the same cycle still sets its bit after the clear. W1C remains functional.
- Undefined: reads have no side effects; PENDING clears only by W1C.

Decomposition:
- rv_pkg gains:
  - ADDRESS_KEYPAD
  - register offset localparams KEYPAD_STATE/PENDING/MASK/EDGE
  - typedef keypad_reg_e (enum of the offsets)
- Sub-module rv_key_debounce, one key: synchroniser, counter, debounced level, press/release pulses. It is parametrised by DEBOUNCE_CYCLES and instantiated N_KEYS times in a generate loop.
- The top holds decode, registers and irq.

Test Plan (N_KEYS=4, DEBOUNCE_CYCLES=4):
- Reset defaults: read all four registers → 0x0 each, rvalid one cycle after each request, irq_o=0.
- Glitch: key0 low for 3 cycles → STATE and PENDING stay 0. Key0 low for 8 cycles → STATE=0x1 and PENDING=0x1 at cycle 6 after the fall.
- Mask/irq: MASK=0x2, press key1 → irq_o=1 one cycle after PENDING[1]. Write PENDING 0x2 → PENDING=0, irq_o=0 next cycle.
- Edge mode: EDGE_MODE=0x8, press and release key3 with PENDING cleared between → PENDING[3] set on both edges. Same for key2 → set on press only.
- Collision: W1C of bit0 in the same cycle as a key0 press event → PENDING[0]=1.
- Byte enables and decode: write MASK 0xFF with be=0b0000 → MASK unchanged. Read at BASE_ADDR+0x10 → no rvalid. With RV_KEYPAD_RC_EN, two reads of PENDING=0x1 → 0x1 then 0x0.
